// File: rtl/game_pkg.sv
// Shared definitions for the prisoner's-dilemma game: strategy codes, move
// encoding and the per-player LFSR step function.
package game_pkg;

    typedef enum logic [2:0] {
        STRAT_ALL_C    = 3'd0,
        STRAT_ALL_D    = 3'd1,
        STRAT_TFT      = 3'd2,
        STRAT_GRUDGER  = 3'd3,
        STRAT_TF2T     = 3'd4,
        STRAT_RANDOM   = 3'd5,
        STRAT_PAVLOV   = 3'd6,
        STRAT_SUSP_TFT = 3'd7
    } strat_e;

    localparam logic DEC_COOP   = 1'b0;
    localparam logic DEC_DEFECT = 1'b1;

    // x^16+x^14+x^13+x^11 Fibonacci form, shifting right: taps at bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/player_strategy.sv
// Combinational move selection for one player from its strategy, the recent
// history of both players, its grudge flag and its LFSR bit.
module player_strategy
    import game_pkg::*;
(
    input  strat_e strategy,
    input  logic   first_round,
    input  logic   own_last,
    input  logic   opp_last,
    input  logic   opp_prev,
    input  logic   grudge,
    input  logic   lfsr_bit,
    output logic   next_move
);

    always_comb begin
        next_move = DEC_COOP;
        if (first_round) begin
            case (strategy)
                STRAT_ALL_D, STRAT_SUSP_TFT: next_move = DEC_DEFECT;
                STRAT_RANDOM:                next_move = lfsr_bit;
                default:                     next_move = DEC_COOP;
            endcase
        end else begin
            case (strategy)
                STRAT_ALL_C:    next_move = DEC_COOP;
                STRAT_ALL_D:    next_move = DEC_DEFECT;
                STRAT_TFT:      next_move = opp_last;
                // the flag only covers earlier rounds, so the move being shifted in counts too
                STRAT_GRUDGER:  next_move = grudge | opp_last;
                STRAT_TF2T:     next_move = opp_last & opp_prev;
                STRAT_RANDOM:   next_move = lfsr_bit;
                STRAT_PAVLOV:   next_move = own_last ^ opp_last;
                STRAT_SUSP_TFT: next_move = opp_last;
                default:        next_move = DEC_COOP;
            endcase
        end
    end

endmodule

// File: rtl/strategy_engine.sv
// Round-by-round move generator for both players; owns all game history,
// grudge, LFSR and defect-counter state.
module strategy_engine
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED_A = 16'hACE1,
    parameter logic [15:0] LFSR_SEED_B = 16'h1D2B,
    parameter int          CNT_W       = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             round_start,
    input  logic             game_active,
    input  logic [2:0]       strategy_a,
    input  logic [2:0]       strategy_b,
    output logic             decision_a,
    output logic             decision_b,
    output logic             decision_valid,
    output logic [CNT_W-1:0] defect_cnt_a,
    output logic [CNT_W-1:0] defect_cnt_b
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // dec_*_q is the newest history entry, prev_*_q the one before it
    logic             first_round_q, first_round_d;
    strat_e           strat_a_q, strat_a_d, strat_b_q, strat_b_d;
    logic             dec_a_q, dec_a_d, dec_b_q, dec_b_d;
    logic             prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic             grudge_a_q, grudge_a_d, grudge_b_q, grudge_b_d;
    logic [15:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             valid_q, valid_d;

    strat_e sel_a, sel_b;
    logic   move_a, move_b;

    // On the opening round the switches are used directly, as they are latched on that same edge
    assign sel_a = first_round_q ? strat_e'(strategy_a) : strat_a_q;
    assign sel_b = first_round_q ? strat_e'(strategy_b) : strat_b_q;

    player_strategy u_player_a (
        .strategy    (sel_a),
        .first_round (first_round_q),
        .own_last    (dec_a_q),
        .opp_last    (dec_b_q),
        .opp_prev    (prev_b_q),
        .grudge      (grudge_a_q),
        .lfsr_bit    (lfsr_a_q[0]),
        .next_move   (move_a)
    );

    player_strategy u_player_b (
        .strategy    (sel_b),
        .first_round (first_round_q),
        .own_last    (dec_b_q),
        .opp_last    (dec_a_q),
        .opp_prev    (prev_a_q),
        .grudge      (grudge_b_q),
        .lfsr_bit    (lfsr_b_q[0]),
        .next_move   (move_b)
    );

    always_comb begin
        first_round_d = first_round_q;
        strat_a_d     = strat_a_q;
        strat_b_d     = strat_b_q;
        dec_a_d       = dec_a_q;
        dec_b_d       = dec_b_q;
        prev_a_d      = prev_a_q;
        prev_b_d      = prev_b_q;
        grudge_a_d    = grudge_a_q;
        grudge_b_d    = grudge_b_q;
        lfsr_a_d      = lfsr_a_q;
        lfsr_b_d      = lfsr_b_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        valid_d       = valid_q;

        // Decisions are deliberately left alone on clear so the final moves stay on the LEDs
        if (!game_active) begin
            first_round_d = 1'b1;
            prev_a_d      = DEC_COOP;
            prev_b_d      = DEC_COOP;
            grudge_a_d    = 1'b0;
            grudge_b_d    = 1'b0;
            lfsr_a_d      = LFSR_SEED_A;
            lfsr_b_d      = LFSR_SEED_B;
            cnt_a_d       = '0;
            cnt_b_d       = '0;
            valid_d       = 1'b0;
        end else if (round_start) begin
            if (first_round_q) begin
                strat_a_d = sel_a;
                strat_b_d = sel_b;
            end else begin
                prev_a_d   = dec_a_q;
                prev_b_d   = dec_b_q;
                grudge_a_d = grudge_a_q | dec_b_q;
                grudge_b_d = grudge_b_q | dec_a_q;
            end
            first_round_d = 1'b0;
            dec_a_d       = move_a;
            dec_b_d       = move_b;
            lfsr_a_d      = lfsr_step(lfsr_a_q);
            lfsr_b_d      = lfsr_step(lfsr_b_q);
            if (move_a == DEC_DEFECT && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
            if (move_b == DEC_DEFECT && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_round_q <= 1'b1;
            strat_a_q     <= STRAT_ALL_C;
            strat_b_q     <= STRAT_ALL_C;
            dec_a_q       <= DEC_COOP;
            dec_b_q       <= DEC_COOP;
            prev_a_q      <= DEC_COOP;
            prev_b_q      <= DEC_COOP;
            grudge_a_q    <= 1'b0;
            grudge_b_q    <= 1'b0;
            lfsr_a_q      <= LFSR_SEED_A;
            lfsr_b_q      <= LFSR_SEED_B;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            first_round_q <= first_round_d;
            strat_a_q     <= strat_a_d;
            strat_b_q     <= strat_b_d;
            dec_a_q       <= dec_a_d;
            dec_b_q       <= dec_b_d;
            prev_a_q      <= prev_a_d;
            prev_b_q      <= prev_b_d;
            grudge_a_q    <= grudge_a_d;
            grudge_b_q    <= grudge_b_d;
            lfsr_a_q      <= lfsr_a_d;
            lfsr_b_q      <= lfsr_b_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            valid_q       <= valid_d;
        end
    end

    assign decision_a     = dec_a_q;
    assign decision_b     = dec_b_q;
    assign decision_valid = valid_q;
    assign defect_cnt_a   = cnt_a_q;
    assign defect_cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_strategy_engine.sv
// Self-checking bench for strategy_engine: directed game scenarios plus a
// randomized run, all checked against a move-list model of the game rules.
module tb_strategy_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       round_start;
    logic       game_active;
    logic [2:0] strategy_a;
    logic [2:0] strategy_b;
    logic       decision_a;
    logic       decision_b;
    logic       decision_valid;
    logic [6:0] defect_cnt_a;
    logic [6:0] defect_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    strategy_engine dut (
        .clk            (clk),
        .reset          (reset),
        .round_start    (round_start),
        .game_active    (game_active),
        .strategy_a     (strategy_a),
        .strategy_b     (strategy_b),
        .decision_a     (decision_a),
        .decision_b     (decision_b),
        .decision_valid (decision_valid),
        .defect_cnt_a   (defect_cnt_a),
        .defect_cnt_b   (defect_cnt_b)
    );

    always #10 clk = ~clk;

    wire [16:0] act_vec = {decision_a, decision_b, decision_valid, defect_cnt_a, defect_cnt_b};

    // Reference model: full move lists of the current game for each player
    bit m_dec_a, m_dec_b;
    bit q_a[$];
    bit q_b[$];
    int m_strat_a, m_strat_b;
    int m_lfsr_a, m_lfsr_b;

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (fb << 15)) & 32'hFFFF;
    endfunction

    function automatic bit model_move(input bit is_a);
        bit own[$];
        bit opp[$];
        int strat, lfsr;
        bit any_d;
        if (is_a) begin own = q_a; opp = q_b; strat = m_strat_a; lfsr = m_lfsr_a; end
        else      begin own = q_b; opp = q_a; strat = m_strat_b; lfsr = m_lfsr_b; end
        if (own.size() == 0) begin
            if (strat == 1 || strat == 7) return 1'b1;
            if (strat == 5) return bit'(lfsr & 1);
            return 1'b0;
        end
        any_d = 1'b0;
        foreach (opp[i]) if (opp[i]) any_d = 1'b1;
        case (strat)
            0: return 1'b0;
            1: return 1'b1;
            2: return opp[$];
            3: return any_d;
            4: return (opp.size() >= 2) && opp[$] && opp[$-1];
            5: return bit'(lfsr & 1);
            6: return own[$] != opp[$];
            default: return opp[$];
        endcase
    endfunction

    function automatic int count_d(input bit is_a);
        int n = 0;
        if (is_a) begin foreach (q_a[i]) n += q_a[i]; end
        else      begin foreach (q_b[i]) n += q_b[i]; end
        return (n > 127) ? 127 : n;
    endfunction

    function automatic logic [16:0] exp_vec();
        logic [6:0] ca, cb;
        ca = 7'(count_d(1'b1));
        cb = 7'(count_d(1'b0));
        return {m_dec_a, m_dec_b, q_a.size() > 0, ca, cb};
    endfunction

    task automatic model_reset();
        m_dec_a = 1'b0;
        m_dec_b = 1'b0;
        q_a.delete();
        q_b.delete();
        m_lfsr_a = 32'hACE1;
        m_lfsr_b = 32'h1D2B;
    endtask

    task automatic model_edge();
        bit na, nb;
        if (!reset) begin
            model_reset();
        end else if (!game_active) begin
            q_a.delete();
            q_b.delete();
            m_lfsr_a = 32'hACE1;
            m_lfsr_b = 32'h1D2B;
        end else if (round_start) begin
            if (q_a.size() == 0) begin
                m_strat_a = int'(strategy_a);
                m_strat_b = int'(strategy_b);
            end
            na = model_move(1'b1);
            nb = model_move(1'b0);
            q_a.push_back(na);
            q_b.push_back(nb);
            m_dec_a = na;
            m_dec_b = nb;
            m_lfsr_a = lfsr_next(m_lfsr_a);
            m_lfsr_b = lfsr_next(m_lfsr_b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic [2:0] sa, input logic [2:0] sb);
        game_active = 1'b0;
        round_start = 1'b0;
        tick();
        strategy_a  = sa;
        strategy_b  = sb;
        game_active = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if (act_vec !== 17'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %h expected %h", act_vec, 17'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        tick();
        vectors++;
        if (act_vec !== 17'h0 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL round_while_idle: got %h expected %h", act_vec, 17'h0);
        end
    endtask

    task automatic test_tft_vs_alld();
        bit ea[3] = '{1'b0, 1'b1, 1'b1};
        start_game(3'd2, 3'd1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            vectors++;
            if (decision_a !== ea[i] || decision_b !== 1'b1 || act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL tft_alld round %0d: got %h expected %h (a=%b b=1)", i, act_vec, exp_vec(), ea[i]);
            end
        end
        vectors++;
        if (defect_cnt_a !== 7'd2 || defect_cnt_b !== 7'd3) begin
            miscompares++;
            $display("[TB] FAIL tft_alld counts: got %0d/%0d expected 2/3", defect_cnt_a, defect_cnt_b);
        end
    endtask

    task automatic test_susp_vs_tf2t();
        bit ea[3] = '{1'b1, 1'b0, 1'b0};
        start_game(3'd7, 3'd4);
        for (int i = 0; i < 3; i++) begin
            pulse();
            vectors++;
            if (decision_a !== ea[i] || decision_b !== 1'b0 || act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL susp_tf2t round %0d: got %h expected %h (a=%b b=0)", i, act_vec, exp_vec(), ea[i]);
            end
        end
        vectors++;
        if (defect_cnt_a !== 7'd1) begin
            miscompares++;
            $display("[TB] FAIL susp_tf2t count_a: got %0d expected 1", defect_cnt_a);
        end
    endtask

    task automatic test_pavlov_switch_ignored();
        bit ea[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        start_game(3'd6, 3'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) strategy_a = 3'd0;
            pulse();
            vectors++;
            if (decision_a !== ea[i] || act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL pavlov round %0d: got %h expected %h (a=%b)", i, act_vec, exp_vec(), ea[i]);
            end
        end
    endtask

    task automatic test_grudger_clear();
        int  guard = 0;
        bit  held_a, held_b;
        start_game(3'd3, 3'd5);
        do begin
            pulse();
            guard++;
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL grudger_wait round %0d: got %h expected %h", guard, act_vec, exp_vec());
            end
        end while (!m_dec_b && guard < 40);
        if (!m_dec_b) begin
            miscompares++;
            $display("[TB] FAIL grudger_wait: no defect from B within 40 rounds");
        end
        for (int i = 0; i < 4; i++) begin
            pulse();
            vectors++;
            if (decision_a !== 1'b1 || act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL grudger_hold round %0d: got %h expected %h (a=1)", i, act_vec, exp_vec());
            end
        end
        held_a = decision_a;
        held_b = decision_b;
        game_active = 1'b0;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        vectors++;
        if (decision_a !== held_a || decision_b !== held_b || decision_valid !== 1'b0 ||
            defect_cnt_a !== 7'd0 || defect_cnt_b !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_hold: got %h expected dec %b%b valid 0 counts 0", act_vec, held_a, held_b);
        end
        game_active = 1'b1;
        pulse();
        vectors++;
        if (decision_a !== 1'b0 || defect_cnt_a !== 7'd0 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL grudger_new_game: got %h expected %h (a=0 cnt_a=0)", act_vec, exp_vec());
        end
    endtask

    task automatic test_saturation_async_reset();
        start_game(3'd1, 3'd0);
        for (int i = 0; i < 130; i++) begin
            pulse();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL saturate round %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        vectors++;
        if (defect_cnt_a !== 7'd127) begin
            miscompares++;
            $display("[TB] FAIL saturate_final: got %0d expected 127", defect_cnt_a);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (act_vec !== 17'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected %h", act_vec, 17'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            game_active = ($urandom_range(0, 19) != 0);
            round_start = $urandom_range(0, 1) == 1;
            strategy_a  = 3'($urandom_range(0, 7));
            strategy_b  = 3'($urandom_range(0, 7));
            tick();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        round_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        round_start = 1'b0;
        game_active = 1'b0;
        strategy_a  = 3'd0;
        strategy_b  = 3'd0;
        model_reset();
        m_strat_a = 0;
        m_strat_b = 0;
        test_reset();
        test_tft_vs_alld();
        test_susp_vs_tf2t();
        test_pavlov_switch_ignored();
        test_grudger_clear();
        test_saturation_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
